// File: rtl/seg_display_8bit.sv
// -----------------------------------------------------------------------------
// seg_display_8bit
//
// Display stage for the microwave timer. An 8-bit binary time value is turned
// into three BCD digits by a sequential shift-add-3 (double-dabble) engine and
// scanned onto a four-digit common-anode seven-segment display. All outputs
// are registered.
//
// Parameters
//   REFRESH_DIV  clk cycles per digit slot (>= 2). 100000 @ 100 MHz = 1 kHz.
//
// Ports
//   clk      in   1  system clock (only clock)
//   reset    in   1  synchronous, active-high reset
//   value    in   8  unsigned binary value to display (0..255)
//   blank    in   1  forces all anodes off; conversion keeps running
//   busy     out  1  high while a conversion is in flight
//   seg_out  out  7  segments, active-low, {g,f,e,d,c,b,a}
//   an_out   out  4  anodes, active-low, an_out[0] = rightmost digit
//
// Configuration macro
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits are blanked
//                          (hundreds if 0, tens if hundreds and tens are 0).
//                          When undefined all three digits are always shown.
// -----------------------------------------------------------------------------
module seg_display_8bit #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value,
  input  logic       blank,
  output logic       busy,
  output logic [6:0] seg_out,
  output logic [3:0] an_out
);

  localparam int             CW          = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  REFRESH_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic [7:0]    r_src;        // last value handed to the converter
  logic          r_src_valid;  // cleared by reset to force a first conversion
  logic [19:0]   r_shift;      // {hundreds, tens, ones, binary}
  logic [2:0]    r_cnt;        // shift step counter, 0..7
  logic          r_busy;
  logic [3:0]    r_dig_h;
  logic [3:0]    r_dig_t;
  logic [3:0]    r_dig_o;
  logic [CW-1:0] r_refresh;
  logic [1:0]    r_scan;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  state_t      w_next_state;
  logic        w_start;
  logic        w_capture;
  logic        w_shift_en;
  logic        w_latch;
  logic [19:0] w_adj;
  logic [3:0]  w_digit;
  logic        w_slot_blank;
  logic [6:0]  w_seg_pat;

  // A conversion is needed whenever the input differs from what the display
  // was last built from, or nothing has been converted since reset.
  assign w_start = (value != r_src) || !r_src_valid;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven from always_comb gets a default first so no path
  // leaves it unassigned (which would infer a latch).
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start)        w_next_state = S_SHIFT;
      S_SHIFT: if (r_cnt == 3'd7)  w_next_state = S_LATCH;
      S_LATCH:                     w_next_state = S_IDLE;
      default:                     w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode (strobes for the datapath)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_capture  = 1'b0;
    w_shift_en = 1'b0;
    w_latch    = 1'b0;
    unique case (r_state)
      S_IDLE:  w_capture  = w_start;
      S_SHIFT: w_shift_en = 1'b1;
      S_LATCH: w_latch    = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Double-dabble step: nibbles >= 5 get +3 before the left shift, so that the
  // doubling carries correctly into the next decimal digit.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_adj = r_shift;
    if (r_shift[19:16] >= 4'd5) w_adj[19:16] = r_shift[19:16] + 4'd3;
    if (r_shift[15:12] >= 4'd5) w_adj[15:12] = r_shift[15:12] + 4'd3;
    if (r_shift[11:8]  >= 4'd5) w_adj[11:8]  = r_shift[11:8]  + 4'd3;
  end

  // ---------------------------------------------------------------------------
  // Conversion datapath. Display digits are only written at LATCH, so a
  // half-converted value is never visible.
  // ---------------------------------------------------------------------------
  // NOTE: all storage here is discrete flops, so all of it is reset; there is
  // no memory array that would need to stay out of the reset tree.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src       <= 8'd0;
      r_src_valid <= 1'b0;
      r_shift     <= 20'd0;
      r_cnt       <= 3'd0;
      r_busy      <= 1'b0;
      r_dig_h     <= 4'd0;
      r_dig_t     <= 4'd0;
      r_dig_o     <= 4'd0;
    end else begin
      if (w_capture) begin
        r_shift     <= {12'd0, value};
        r_src       <= value;
        r_src_valid <= 1'b1;
        r_cnt       <= 3'd0;
        r_busy      <= 1'b1;
      end
      if (w_shift_en) begin
        r_shift <= {w_adj[18:0], 1'b0};
        r_cnt   <= r_cnt + 3'd1;
      end
      if (w_latch) begin
        r_dig_h <= r_shift[19:16];
        r_dig_t <= r_shift[15:12];
        r_dig_o <= r_shift[11:8];
        r_busy  <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan timing: refresh counter wraps every REFRESH_DIV cycles and advances
  // the slot index 0..3 (the 2-bit index wraps naturally).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh <= '0;
      r_scan    <= 2'd0;
    end else if (r_refresh == REFRESH_MAX) begin
      r_refresh <= '0;
      r_scan    <= r_scan + 2'd1;
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot decode: digit selection and blanking of the current slot.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_digit      = 4'd0;
    w_slot_blank = 1'b0;
    unique case (r_scan)
      2'd0: w_digit = r_dig_o;
      2'd1: begin
        w_digit = r_dig_t;
`ifdef LEADING_ZERO_BLANK_EN
        w_slot_blank = (r_dig_h == 4'd0) && (r_dig_t == 4'd0);
`else
        w_slot_blank = 1'b0;
`endif
      end
      2'd2: begin
        w_digit = r_dig_h;
`ifdef LEADING_ZERO_BLANK_EN
        w_slot_blank = (r_dig_h == 4'd0);
`else
        w_slot_blank = 1'b0;
`endif
      end
      default: w_slot_blank = 1'b1;  // slot 3 has no digit
    endcase
  end

  always_comb begin
    w_seg_pat = 7'b1111111;
    unique case (w_digit)
      4'd0:    w_seg_pat = 7'b1000000;
      4'd1:    w_seg_pat = 7'b1111001;
      4'd2:    w_seg_pat = 7'b0100100;
      4'd3:    w_seg_pat = 7'b0110000;
      4'd4:    w_seg_pat = 7'b0011001;
      4'd5:    w_seg_pat = 7'b0010010;
      4'd6:    w_seg_pat = 7'b0000010;
      4'd7:    w_seg_pat = 7'b1111000;
      4'd8:    w_seg_pat = 7'b0000000;
      4'd9:    w_seg_pat = 7'b0010000;
      default: w_seg_pat = 7'b1111111;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered output drive (one cycle behind scan index and blank).
  // The blank input only gates the anodes; segment data keeps following the
  // slot so the digit reappears cleanly when blank drops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      an_out  <= 4'b1111;
      seg_out <= 7'b1111111;
    end else begin
      an_out  <= (blank || w_slot_blank) ? 4'b1111 : ~(4'b0001 << r_scan);
      seg_out <= w_slot_blank ? 7'b1111111 : w_seg_pat;
    end
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_seg_display_8bit.sv
// -----------------------------------------------------------------------------
// tb_seg_display_8bit
//
// Directed bench for seg_display_8bit with REFRESH_DIV = 4. Expected digits
// come from integer division of the driven value; the expected slot for each
// sample comes from a cycle count kept since the last reset release.
// Honors LEADING_ZERO_BLANK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_seg_display_8bit;

  localparam int DIV = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value = 8'd0;
  logic       blank = 1'b0;
  logic       busy;
  logic [6:0] seg_out;
  logic [3:0] an_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;   // rising edges since reset was last released

  seg_display_8bit #(.REFRESH_DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .blank   (blank),
    .busy    (busy),
    .seg_out (seg_out),
    .an_out  (an_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [6:0] seg_pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Outputs sampled after edge k reflect the slot index held before edge k.
  task automatic check_slot(input int v, input string tag);
    int         slot;
    int         dig [3];
    bit         shown;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    slot   = ((cyc - 1) / DIV) % 4;
    dig[0] = v % 10;
    dig[1] = (v / 10) % 10;
    dig[2] = v / 100;
    shown  = (slot < 3);
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 2) shown = (dig[2] != 0);
    if (slot == 1) shown = (dig[2] != 0) || (dig[1] != 0);
`endif
    exp_an  = shown ? ~(4'b0001 << slot) : 4'b1111;
    exp_seg = shown ? seg_pat(dig[slot]) : 7'b1111111;
    if (blank) begin
      check({tag, "_an_blank"}, 32'(an_out), 32'(4'b1111));
    end else begin
      check({tag, "_an"},  32'(an_out),  32'(exp_an));
      check({tag, "_seg"}, 32'(seg_out), 32'(exp_seg));
    end
  endtask

  task automatic check_frame(input int v, input string tag);
    for (int i = 0; i < 4 * DIV; i++) begin
      check_slot(v, tag);
      step();
    end
  endtask

  // Counts consecutive busy-high samples starting at the current one.
  task automatic busy_run(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    int rises;
    int highs;
    bit prev;

    // ---- reset state, then 255 ---------------------------------------------
    @(negedge clk);
    reset = 1'b1;
    value = 8'd255;
    step();
    step();
    check("rst_an",   32'(an_out),  32'(4'b1111));
    check("rst_seg",  32'(seg_out), 32'(7'b1111111));
    check("rst_busy", 32'(busy),    32'd0);
    reset = 1'b0;
    step();
    check("v255_busy_rise", 32'(busy), 32'd1);
    busy_run(n);
    check("v255_busy_len", 32'(n), 32'd9);
    step();
    check_frame(255, "v255");

    // ---- zero ---------------------------------------------------------------
    value = 8'd0;
    step();
    busy_run(n);
    check("v0_busy_len", 32'(n), 32'd9);
    step();
    check_frame(0, "v0");

    // ---- 12 then 200 arriving during SHIFT ----------------------------------
    value = 8'd12;
    step();
    step();
    step();
    value = 8'd200;
    busy_run(n);
    check("v12_busy_len", 32'(n), 32'd7);
    check("v12_idle_gap", 32'(busy), 32'd0);
    step();
    check("v200_busy_rise", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 40) begin
      check_slot(12, "v12_hold");
      n++;
      step();
    end
    check("v200_busy_len", 32'(n), 32'd9);
    check_slot(12, "v12_last");
    step();
    check_frame(200, "v200");

    // ---- blank while showing 99 --------------------------------------------
    value = 8'd99;
    step();
    busy_run(n);
    check("v99_busy_len", 32'(n), 32'd9);
    step();
    blank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_slot(99, "blank");
    end
    blank = 1'b0;
    step();
    check_slot(99, "unblank");
    check_frame(99, "v99");

    // ---- reset four cycles into a conversion --------------------------------
    value = 8'd150;
    step();
    step();
    step();
    step();
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_an",   32'(an_out),  32'(4'b1111));
    check("mid_rst_seg",  32'(seg_out), 32'(7'b1111111));
    check("mid_rst_busy", 32'(busy),    32'd0);
    reset = 1'b0;
    step();
    check("mid_busy_rise", 32'(busy), 32'd1);
    busy_run(n);
    check("mid_busy_len", 32'(n), 32'd9);
    step();
    check_frame(150, "v150");

    // ---- constant value: exactly one conversion after reset -----------------
    reset = 1'b1;
    step();
    reset = 1'b0;
    rises = 0;
    highs = 0;
    prev  = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (busy && !prev) rises++;
      if (busy) highs++;
      prev = busy;
    end
    check("const_rises", 32'(rises), 32'd1);
    check("const_highs", 32'(highs), 32'd9);
    check("const_busy_end", 32'(busy), 32'd0);
    check_frame(150, "const");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_display_8bit.md
# seg_display_8bit

Downstream display stage for the microwave timer. It takes the 8-bit time value from the timer control FSM, converts it to three decimal digits with a sequential shift-add-3 (double-dabble) engine, and time-multiplexes the digits onto the four-digit common-anode seven-segment display. It sits between the control FSM's `disp` value and the board's `seg`/`an` pins. All outputs are registered.

## Interface
- `REFRESH_DIV`, default 100000: `clk` cycles per digit slot. At 100 MHz this gives 1 kHz per digit and 250 Hz per frame. Legal range is ≥ 2.
- `clk` input, 1 bit: system clock, 100 MHz. This is the only clock.
- `reset` input, 1 bit: synchronous, active-high reset.
- `value` input, 8 bits: unsigned binary value to display, range 0–255.
- `blank` input, 1 bit: while high, all anodes are off. Conversion continues.
- `busy` output, 1 bit: high while a conversion is in flight.
- `seg_out` output, 7 bits: segments, active-low, ordered {g,f,e,d,c,b,a}.
- `an_out` output, 4 bits: anodes, active-low. `an_out[0]` is the rightmost digit.

## Operation
- Reset values:
  - `an_out` = 4'b1111, `seg_out` = 7'b1111111, `busy` = 0.
  - Stored digits = 0, scan index = 0, refresh counter = 0.
  - `src` (last converted value) is marked invalid, which forces a conversion in the first cycle after reset.
- Conversion FSM has states IDLE, SHIFT, LATCH.
  - IDLE: if `value != src` or `src` is invalid, capture `value` into the shift register and `src`, clear the BCD registers, set `busy`=1, and go to SHIFT.
  - SHIFT: runs for exactly 8 cycles. In each cycle, every BCD nibble ≥ 5 gets +3, then the 20-bit {BCD, bin} register shifts left by 1. A 3-bit counter ends the phase.
  - LATCH: copy hundreds, tens and ones into the display digit registers, clear `busy`, return to IDLE.
- Changes on `value` during SHIFT or LATCH are ignored. On return to IDLE, a still-different `value` starts a new conversion immediately. The last stable value is always the one that ends up displayed.
- The displayed digits change only at LATCH. Partially converted digits never reach the display.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances 0→1→2→3→0.
  - Slots: index 0 = ones, 1 = tens, 2 = hundreds, 3 = unused. In the unused slot `an_out` = 4'b1111 and `seg_out` = 7'b1111111.
- Output drive:
  - `an_out` is the one-hot-low of the scan index, unless `blank` is high or the slot is blanked, in which case `an_out` = 4'b1111.
  - `seg_out` is the 7-segment pattern of the current digit. Patterns for 0–9 are: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - A blanked slot drives `seg_out` = 7'b1111111.
- Simultaneous events: a scan wrap and a LATCH in the same cycle are legal. The new digit is shown from the next registered output.

## Timing
- Conversion latency: if `value` changes before edge t while in IDLE, capture happens at t, SHIFT covers t+1..t+8, LATCH is t+9. New digits drive the outputs starting at edge t+10.
- `busy` is high from the edge after t through the LATCH cycle, i.e. 9 cycles.
- `an_out`/`seg_out` are registered and follow the scan index and `blank` with 1 cycle of latency.
- Reset mid-conversion: the conversion aborts, all outputs take their reset values on that edge, and a fresh conversion starts on the first cycle after `reset` deasserts.
- Each anode is active for exactly REFRESH_DIV cycles per slot, except slot 3, which is never active.

## Configuration
- `LEADING_ZERO_BLANK_EN`:
  - Defined: hundreds is blanked when it is 0, and tens is blanked when both hundreds and tens are 0. Ones is never blanked. Example: 7 shows as "  7" on digit 0 only.
  - Undefined: all three digits are always shown. Example: 7 shows as "007".

## Test plan
All scenarios use REFRESH_DIV=4.
- Reset then `value`=8'd255 → `busy` high for 9 cycles. Over a full frame, `an_out` cycles 1110/1101/1011/1111 with `seg_out` 0010010/0010010/0100100/1111111.
- `value`=0 with the macro defined → only `an_out`=1110 is ever low and `seg_out`=1000000. With the macro undefined → three digits each show 1000000.
- `value` changes 12→200 during SHIFT → digits show 12 after the first LATCH, then a second conversion runs and the display settles on "200". No intermediate digits ever appear.
- `blank`=1 for 20 cycles while `value`=99 → `an_out`=1111 throughout. When `blank` drops, the first slot is shown within 1 cycle.
- `reset` asserted 4 cycles into a conversion → outputs read 1111/1111111 and `busy`=0 on that edge. After release, `busy` rises on the next cycle and "value" is shown 10 cycles later.
- `value` held constant for 1000 cycles → exactly one conversion happens after reset, and `busy` stays 0 afterwards.
